// File: rtl/quant_pkg.sv
// Shared types and constants for the feature quantizer/packer input stage.
package quant_pkg;

    localparam int unsigned CODE_W   = 2;
    localparam int unsigned N_THR    = 3;
    localparam int unsigned FEAT_W   = 16;
    localparam int unsigned MAX_FEAT = 8;

    // Threshold triple for one feature, t0 < t1 < t2, all signed.
    typedef struct packed {
        logic signed [FEAT_W-1:0] t2;
        logic signed [FEAT_W-1:0] t1;
        logic signed [FEAT_W-1:0] t0;
    } thr_t;

    typedef enum logic {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } state_t;

    function automatic thr_t mk_thr(input int a, input int b, input int c);
        thr_t t;
        t.t0 = a[FEAT_W-1:0];
        t.t1 = b[FEAT_W-1:0];
        t.t2 = c[FEAT_W-1:0];
        return t;
    endfunction

    // Default per-feature thresholds, indexed by beat position within a vector.
    localparam thr_t DEF_THR [MAX_FEAT] = '{
        mk_thr(  -100,     0,   100),
        mk_thr( -2000,  -500,  1000),
        mk_thr(-32768,     0, 32767),
        mk_thr(   -50,   -49,   -48),
        mk_thr(  1000,  2000,  3000),
        mk_thr( -3000, -2000, -1000),
        mk_thr(-16384,     0, 16384),
        mk_thr(    -1,     0,     1)
    };

endpackage

// File: rtl/quant_thresh_rom.sv
// Combinational threshold lookup: beat index in, threshold triple out.
module quant_thresh_rom
    import quant_pkg::*;
#(
    parameter int unsigned N_FEAT = 8,
    parameter int unsigned IDX_W  = 3
) (
    input  logic [IDX_W-1:0] i_idx,
    output thr_t             o_thr
);

    localparam int unsigned N_ENT = (N_FEAT < MAX_FEAT) ? N_FEAT : MAX_FEAT;

    // Small table lookup; unmapped indices return all-zero thresholds.
    always_comb begin
        o_thr = '0;
        for (int unsigned i = 0; i < N_ENT; i++) begin
            if (i_idx == IDX_W'(i)) begin
                o_thr = DEF_THR[i];
            end
        end
    end

endmodule

// File: rtl/feature_quantizer_packer.sv
// Quantizes raw signed features to 2-bit codes and packs N_FEAT of them into
// one vector, with a collect buffer and a shadow output register so the next
// vector can be gathered while the current one drains.
module feature_quantizer_packer
    import quant_pkg::*;
#(
    parameter int unsigned N_FEAT = 8,
    parameter int unsigned IN_W   = FEAT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [IN_W-1:0]   s_data,
    input  logic                     s_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [2*N_FEAT-1:0]      m_data,
    output logic                     err_len
);

    localparam int unsigned IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

    state_t                           r_state;
    state_t                           w_state_nxt;
    logic [IDX_W-1:0]                 r_idx;
    logic [N_FEAT-1:0][CODE_W-1:0]    r_coll;
    logic [N_FEAT-1:0][CODE_W-1:0]    r_out;
    logic [N_FEAT-1:0][CODE_W-1:0]    w_full;
    logic                             r_mvalid;
    logic                             r_err;

    thr_t                             w_thr;
    logic                             w_ge0;
    logic                             w_ge1;
    logic                             w_ge2;
    logic [CODE_W-1:0]                w_code;
    logic                             w_acc;
    logic                             w_drain;
    logic                             w_last_idx;
    logic                             w_can_load;

    quant_thresh_rom #(
        .N_FEAT (N_FEAT),
        .IDX_W  (IDX_W)
    ) u_rom (
        .i_idx  (r_idx),
        .o_thr  (w_thr)
    );

    assign w_acc      = s_valid && (r_state == COLLECT);
    assign w_drain    = r_mvalid && m_ready;
    assign w_last_idx = (r_idx == IDX_W'(N_FEAT - 1));
    assign w_can_load = !r_mvalid || w_drain;

    assign m_valid = r_mvalid;
    assign m_data  = r_out;
    assign err_len = r_err;

    // Code = number of thresholds the sample meets or exceeds (signed compare).
    always_comb begin
        w_ge0  = s_data >= $signed(w_thr.t0);
        w_ge1  = s_data >= $signed(w_thr.t1);
        w_ge2  = s_data >= $signed(w_thr.t2);
        w_code = CODE_W'(w_ge0) + CODE_W'(w_ge1) + CODE_W'(w_ge2);
    end

    // Completed vector as it would look with this beat's code merged in.
    always_comb begin
        w_full        = r_coll;
        w_full[r_idx] = w_code;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and input-ready: stall when a full vector cannot reach the output register.
    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        unique case (r_state)
            COLLECT: begin
                s_ready = 1'b1;
                if (s_valid && w_last_idx && !w_can_load) begin
                    w_state_nxt = STALL;
                end
            end
            STALL: begin
                if (w_drain) begin
                    w_state_nxt = COLLECT;
                end
            end
            default: w_state_nxt = COLLECT;
        endcase
    end

    // Beat index, collect buffer, output register and framing error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_coll   <= '0;
            r_out    <= '0;
            r_mvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_drain) begin
                r_mvalid <= 1'b0;
            end
            if ((r_state == STALL) && w_drain) begin
                r_out    <= r_coll;
                r_mvalid <= 1'b1;
            end
            if (w_acc) begin
                if (w_last_idx) begin
                    r_idx <= '0;
                    r_err <= !s_last;
                    if (w_can_load) begin
                        r_out    <= w_full;
                        r_mvalid <= 1'b1;
                    end else begin
                        r_coll[r_idx] <= w_code;
                    end
                end else if (s_last) begin
                    r_idx <= '0;
                    r_err <= 1'b1;
                end else begin
                    r_coll[r_idx] <= w_code;
                    r_idx         <= r_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_feature_quantizer_packer.sv
// Randomized self-checking bench for feature_quantizer_packer with a queue-based reference model.
module tb_feature_quantizer_packer;

    localparam int NF = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic signed [15:0] s_data = '0;
    logic               s_last = 1'b0;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic [15:0]        m_data;
    logic               err_len;

    always #5 clk = ~clk;

    feature_quantizer_packer #(
        .N_FEAT (NF),
        .IN_W   (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .err_len (err_len)
    );

    int THR [NF][3] = '{
        '{  -100,     0,   100},
        '{ -2000,  -500,  1000},
        '{-32768,     0, 32767},
        '{   -50,   -49,   -48},
        '{  1000,  2000,  3000},
        '{ -3000, -2000, -1000},
        '{-16384,     0, 16384},
        '{    -1,     0,     1}
    };

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] q[$];      // vectors owned by the stage, front = on m_data
    int          frame[$];  // codes of the vector being collected
    bit          exp_err = 1'b0;
    bit          accepted = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int quant(input int f, input int x);
        int c = 0;
        for (int k = 0; k < 3; k++) if (x >= THR[f][k]) c++;
        return c;
    endfunction

    function automatic logic [15:0] pack_frame();
        logic [15:0] v = '0;
        for (int i = 0; i < NF; i++) v[2*i +: 2] = 2'(frame[i]);
        return v;
    endfunction

    function automatic int clamp16(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic int rand_feat(input int f);
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 65535)) - 32768;
        return clamp16(THR[f][$urandom_range(0, 2)] + int'($urandom_range(0, 2)) - 1);
    endfunction

    // One clock cycle: drive, update the model at the edge, check at the falling edge.
    task automatic step(input bit sv, input bit sl, input int sd, input bit mr);
        bit rdy, drain, acc;
        s_valid = sv;
        s_last  = sl;
        s_data  = 16'(sd);
        m_ready = mr;
        rdy   = (q.size() < 2);
        drain = (q.size() > 0) && mr;
        acc   = sv && rdy;
        @(posedge clk);
        exp_err = 1'b0;
        if (drain) void'(q.pop_front());
        if (acc) begin
            frame.push_back(quant(frame.size(), sd));
            if (frame.size() == NF) begin
                q.push_back(pack_frame());
                exp_err = !sl;
                frame.delete();
            end else if (sl) begin
                exp_err = 1'b1;
                frame.delete();
            end
        end
        accepted = acc;
        @(negedge clk);
        check("m_valid", m_valid, q.size() > 0);
        check("s_ready", s_ready, q.size() < 2);
        check("err_len", err_len, exp_err);
        if (q.size() > 0) check("m_data", m_data, q[0]);
    endtask

    // mode: 0 = m_ready low, 1 = m_ready high, 2 = random
    task automatic send_beat(input int sd, input bit sl, input int mode);
        bit mr;
        for (int t = 0; t < 200; t++) begin
            mr = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'(mode);
            step(1'b1, sl, sd, mr);
            if (accepted) return;
        end
        check("accept_timeout", 0, 1);
    endtask

    task automatic send_rand_vec(input int mode, input int first);
        send_beat(first, 1'b0, mode);
        for (int i = 1; i < NF; i++) send_beat(rand_feat(i), i == NF - 1, mode);
    endtask

    task automatic flush();
        for (int t = 0; t < 20 && q.size() > 0; t++) step(1'b0, 1'b0, 0, 1'b1);
        check("flush_empty", q.size(), 0);
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        s_data  = '0;
        rst_n   = 1'b0;
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_err_len", err_len, 0);
        q.delete();
        frame.delete();
        exp_err = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_s_ready", s_ready, 1);
        check("post_rst_m_valid", m_valid, 0);
    endtask

    int          F0_IN  [6] = '{-101, -100, 0, 100, 32767, -32768};
    logic [1:0]  F0_EXP [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
    logic [15:0] vec_a, vec_b;

    initial begin
        #2;
        do_reset();

        // Feature-0 quantization points, continuous stream with m_ready high.
        for (int k = 0; k < 6; k++) begin
            send_rand_vec(1, F0_IN[k]);
            check("f0_valid", m_valid, 1);
            check("f0_code", m_data[1:0], F0_EXP[k]);
        end
        flush();

        // Back-to-back random vectors at full rate.
        for (int k = 0; k < 6; k++) send_rand_vec(1, rand_feat(0));
        flush();

        // Two vectors arrive while layer 1 is not ready.
        send_rand_vec(0, rand_feat(0));
        vec_a = q[0];
        send_rand_vec(0, rand_feat(0));
        vec_b = q[1];
        for (int t = 0; t < 3; t++) begin
            step(1'b1, 1'b0, rand_feat(0), 1'b0);
            check("stall_s_ready", s_ready, 0);
            check("stall_hold", m_data, vec_a);
        end
        step(1'b0, 1'b0, 0, 1'b1);
        check("stall_exit_valid", m_valid, 1);
        check("stall_exit_data", m_data, vec_b);
        check("stall_exit_ready", s_ready, 1);
        flush();

        // Early s_last on idx 3 discards the partial vector.
        for (int i = 0; i < 4; i++) send_beat(rand_feat(i), i == 3, 1);
        check("short_err", err_len, 1);
        check("short_no_valid", m_valid, 0);
        send_rand_vec(1, rand_feat(0));
        check("after_short_valid", m_valid, 1);
        flush();

        // Missing s_last on idx 7: vector still emitted, error alongside it.
        for (int i = 0; i < NF; i++) send_beat(rand_feat(i), 1'b0, 1);
        check("missing_err", err_len, 1);
        check("missing_valid", m_valid, 1);
        flush();

        // Random traffic with back-pressure and occasional framing errors.
        for (int t = 0; t < 600; t++) begin
            bit sl;
            if (frame.size() == NF - 1) sl = ($urandom_range(0, 9) < 9);
            else                        sl = ($urandom_range(0, 29) == 0);
            step($urandom_range(0, 9) < 7, sl, rand_feat(frame.size()),
                 $urandom_range(0, 9) < 6);
        end

        // Reset mid-traffic, then a clean vector.
        do_reset();
        send_rand_vec(1, rand_feat(0));
        check("rst_mid_recover", m_valid, 1);
        flush();

        // Reset while stalled.
        send_rand_vec(0, rand_feat(0));
        send_rand_vec(0, rand_feat(0));
        step(1'b1, 1'b0, 5, 1'b0);
        check("pre_rst_stall", s_ready, 0);
        do_reset();
        step(1'b0, 1'b0, 0, 1'b1);
        send_rand_vec(1, rand_feat(0));
        check("rst_stall_recover", m_valid, 1);
        flush();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
